fetch_align: RTL and testbench



---
 rtl/fetch_align.sv | 157 +++++++++++++++
 tb/tb_fetch_align.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// Instruction fetch/align stage: word fetches into a halfword queue,
// one (possibly straddling) instruction presented per handshake.
module fetch_align #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_WORDS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        align_valid_o,
    input  logic        align_ready_i,
    output logic [31:0] align_inst_o,
    output logic [31:0] align_pc_o,
    output logic        align_com_o
);

    localparam int HW = 2 * BUF_WORDS;            // queue depth in halfwords
    localparam int CW = $clog2(HW + 1) + 1;       // one spare bit for base+1

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state_q, state_d;
    logic [HW-1:0][15:0]  hwq_q, hwq_d;           // index 0 is the head halfword
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          fetch_addr_q, fetch_addr_d;
    logic [31:0]          head_pc_q, head_pc_d;
    logic                 outst_q, outst_d;       // granted, response not yet seen
    logic                 discard_q, discard_d;   // that response is stale
    logic                 skip_q, skip_d;         // drop low halfword of next push
    logic [31:0]          hold_inst_q, hold_pc_q;
    logic                 hold_com_q;

    logic                 is32, valid, consume, grant, rsp, push;
    logic [31:0]          cur_inst;
    logic [CW-1:0]        pop_n, push_n, base;
    logic                 unused_pc0;

    // target bit 0 is meaningless for halfword-aligned code
    assign unused_pc0 = flush_pc_i[0];

    // head decode: a 32-bit instruction needs both halfwords present
    always_comb begin
        is32     = &hwq_q[0][1:0];
        valid    = is32 ? (cnt_q >= CW'(2)) : (cnt_q >= CW'(1));
        cur_inst = is32 ? {hwq_q[1], hwq_q[0]} : {16'h0000, hwq_q[0]};
    end

    assign align_valid_o = valid;
    assign align_inst_o  = valid ? cur_inst  : hold_inst_q;
    assign align_pc_o    = valid ? head_pc_q : hold_pc_q;
    assign align_com_o   = valid ? ~is32     : hold_com_q;
    assign imem_addr_o   = fetch_addr_q;

    assign consume = valid & align_ready_i & ~flush_i;
    assign grant   = imem_req_o & imem_gnt_i;
    assign rsp     = imem_rvalid_i & outst_q;
    assign push    = rsp & ~discard_q & ~flush_i;

    // queue update: pop from the head, then append the returned word behind it
    always_comb begin
        pop_n  = consume ? (is32 ? CW'(2) : CW'(1)) : CW'(0);
        push_n = push ? (skip_q ? CW'(1) : CW'(2)) : CW'(0);
        base   = cnt_q - pop_n;
        hwq_d  = hwq_q;
        if (consume) hwq_d = is32 ? (hwq_q >> 32) : (hwq_q >> 16);
        for (int i = 0; i < HW; i++) begin
            if (push && CW'(i) == base)
                hwq_d[i] = skip_q ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
            if (push && !skip_q && CW'(i) == base + CW'(1))
                hwq_d[i] = imem_rdata_i[31:16];
        end
        cnt_d = flush_i ? CW'(0) : base + push_n;
    end

    // pointers and response bookkeeping; a redirect overrides everything
    always_comb begin
        outst_d      = grant | (outst_q & ~rsp);
        discard_d    = rsp ? 1'b0 : discard_q;
        skip_d       = push ? 1'b0 : skip_q;
        head_pc_d    = consume ? head_pc_q + (is32 ? 32'd4 : 32'd2) : head_pc_q;
        fetch_addr_d = grant ? fetch_addr_q + 32'd4 : fetch_addr_q;
        if (flush_i) begin
            // anything still in flight after this cycle belongs to the old path
            discard_d    = outst_d;
            skip_d       = flush_pc_i[1];
            head_pc_d    = {flush_pc_i[31:1], 1'b0};
            fetch_addr_d = {flush_pc_i[31:2], 2'b00};
        end
    end

    // fetch FSM; IDLE only issues with no response in flight so at most one
    // is ever outstanding and its two halfwords always have room
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_ni && !flush_i && !outst_q && cnt_q <= CW'(HW - 2)) begin
                    imem_req_o = 1'b1;
                    state_d    = imem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (rsp) state_d = (cnt_d <= CW'(HW - 2)) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            hwq_q        <= '0;
            cnt_q        <= '0;
            fetch_addr_q <= RESET_PC;
            head_pc_q    <= RESET_PC;
            outst_q      <= 1'b0;
            discard_q    <= 1'b0;
            skip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hwq_q        <= hwq_d;
            cnt_q        <= cnt_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            skip_q       <= skip_d;
        end
    end

    // remember the last presented instruction so outputs hold while invalid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_inst_q <= '0;
            hold_pc_q   <= RESET_PC;
            hold_com_q  <= 1'b0;
        end else if (valid) begin
            hold_inst_q <= cur_inst;
            hold_pc_q   <= head_pc_q;
            hold_com_q  <= ~is32;
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: a memory responder, an expected-instruction
// queue filled as memory images are loaded, and a handshake monitor.
module tb_fetch_align;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        align_valid_o;
    logic        align_ready_i;
    logic [31:0] align_inst_o;
    logic [31:0] align_pc_o;
    logic        align_com_o;

    fetch_align #(.RESET_PC(32'h0000_0000), .BUF_WORDS(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .align_valid_o(align_valid_o), .align_ready_i(align_ready_i),
        .align_inst_o(align_inst_o), .align_pc_o(align_pc_o), .align_com_o(align_com_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        com;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0, n_err = 0;
    int          lat_cnt = 0, lat_min = 1, lat_max = 1, n_gnt = 0;
    logic [31:0] pend_addr = '0;
    bit          gnt_rand = 1'b0, rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0001_0001;   // c.nop pairs beyond any loaded image
    endfunction

    function automatic void expect_inst(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic com);
        exp_t e;
        e.inst = inst; e.pc = pc; e.com = com;
        exp_q.push_back(e);
    endfunction

    // memory: grant on the negedge half, respond lat_cnt cycles after the grant
    initial begin
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            imem_rvalid_i = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_rd(pend_addr);
                end
            end
            imem_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (rst_ni && imem_req_o && imem_gnt_i) begin
                if (lat_cnt != 0) chk("second_outstanding", 32'(lat_cnt), 32'd0);
                pend_addr = imem_addr_o;
                lat_cnt   = lat_min + int'($urandom_range(0, lat_max - lat_min));
                n_gnt++;
            end
        end
    end

    // handshake monitor: every accepted instruction must match the queue head
    always @(negedge clk_i) begin
        exp_t e;
        #2;
        if (rst_ni && align_valid_o && align_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                chk("extra_inst", align_inst_o, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("inst", align_inst_o, e.inst);
                chk("pc",   align_pc_o,   e.pc);
                chk("com",  {31'b0, align_com_o}, {31'b0, e.com});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_flush(input logic [31:0] pc);
        @(negedge clk_i);
        flush_i = 1'b1; flush_pc_i = pc;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
            @(negedge clk_i);
            align_ready_i = (exp_q.size() != 0) && (!rnd_ready || $urandom_range(0, 3) != 0);
        end
        align_ready_i = 1'b0;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        bit          found;
        logic [15:0] hws[$];
        logic [15:0] c;
        logic [31:0] w, pc;

        rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = '0; align_ready_i = 1'b0;
        mem[32'h0] = 32'h0051_0093;

        // reset state
        @(negedge clk_i); #2;
        chk("rst_req",   {31'b0, imem_req_o},    32'd0);
        chk("rst_addr",  imem_addr_o,            32'h0);
        chk("rst_valid", {31'b0, align_valid_o}, 32'd0);
        chk("rst_inst",  align_inst_o,           32'h0);
        chk("rst_pc",    align_pc_o,             32'h0);
        chk("rst_com",   {31'b0, align_com_o},   32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // first word: valid exactly one cycle after rvalid
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_i); #2;
            found = imem_rvalid_i;
        end
        chk("s1_rvalid_seen", {31'b0, found}, 32'd1);
        @(negedge clk_i); #2;
        chk("s1_valid", {31'b0, align_valid_o}, 32'd1);
        chk("s1_inst",  align_inst_o, 32'h0051_0093);
        chk("s1_pc",    align_pc_o,   32'h0);
        chk("s1_com",   {31'b0, align_com_o}, 32'd0);
        expect_inst(32'h0051_0093, 32'h0, 1'b0);
        drain(100);

        // two compressed instructions from one word, jittery grants
        gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
        mem[32'h40] = 32'h4501_4581;
        do_flush(32'h40);
        expect_inst(32'h0000_4581, 32'h40, 1'b1);
        expect_inst(32'h0000_4501, 32'h42, 1'b1);
        drain(200);

        // straddling 32-bit instruction waits for its second word
        gnt_rand = 1'b0; lat_min = 4; lat_max = 4;
        mem[32'h100] = 32'h0093_4581;
        mem[32'h104] = 32'hABCD_0051;
        do_flush(32'h100);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk_i); #2;
            found = imem_rvalid_i && pend_addr == 32'h100;
        end
        chk("s3_rvalid_seen", {31'b0, found}, 32'd1);
        expect_inst(32'h0000_4581, 32'h100, 1'b1);
        expect_inst(32'h0051_0093, 32'h102, 1'b0);
        @(negedge clk_i);
        align_ready_i = 1'b1;
        #3;
        chk("s3_c_valid", {31'b0, align_valid_o}, 32'd1);
        @(negedge clk_i);
        align_ready_i = 1'b0;
        #3;
        chk("s3_wait_valid", {31'b0, align_valid_o}, 32'd0);
        chk("s3_hold_inst",  align_inst_o, 32'h0000_4581);
        chk("s3_hold_pc",    align_pc_o,   32'h100);
        chk("s3_hold_com",   {31'b0, align_com_o}, 32'd1);
        drain(200);

        // redirect to a halfword-aligned target skips the low halfword
        lat_min = 1; lat_max = 2;
        mem[32'h1004] = 32'h4581_FFFF;
        mem[32'h1008] = 32'h0051_0093;
        do_flush(32'h0000_1006);
        #2;
        chk("s4_addr",  imem_addr_o, 32'h1004);
        chk("s4_valid", {31'b0, align_valid_o}, 32'd0);
        expect_inst(32'h0000_4581, 32'h1006, 1'b1);
        expect_inst(32'h0051_0093, 32'h1008, 1'b0);
        drain(200);

        // redirect while a response is pending: stale word must vanish
        lat_min = 2; lat_max = 2;
        mem[32'h200] = 32'h4501_4501;
        mem[32'h300] = 32'h0051_0093;
        do_flush(32'h200);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk_i); #3;
            found = (lat_cnt == 1) && (pend_addr == 32'h200);
        end
        chk("s5_pending_seen", {31'b0, found}, 32'd1);
        flush_i = 1'b1; flush_pc_i = 32'h300;
        @(negedge clk_i);
        flush_i = 1'b0;
        #3;
        chk("s5_addr", imem_addr_o, 32'h300);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_i); #3;
            found = imem_req_o;
            if (found) chk("s5_req_addr", imem_addr_o, 32'h300);
        end
        chk("s5_req_seen", {31'b0, found}, 32'd1);
        expect_inst(32'h0051_0093, 32'h300, 1'b0);
        drain(200);

        // stalled consumer: exactly two words fetched, refetch after one pop
        lat_min = 1; lat_max = 1;
        mem[32'h400] = 32'h0051_0093;
        mem[32'h404] = 32'h00A0_0113;
        do_flush(32'h400);
        n_gnt = 0;
        repeat (20) @(negedge clk_i);
        #3;
        chk("s6_grants", 32'(n_gnt), 32'd2);
        chk("s6_req_off", {31'b0, imem_req_o}, 32'd0);
        expect_inst(32'h0051_0093, 32'h400, 1'b0);
        expect_inst(32'h00A0_0113, 32'h404, 1'b0);
        @(negedge clk_i);
        align_ready_i = 1'b1;
        @(negedge clk_i);
        align_ready_i = 1'b0;
        #3;
        chk("s6_req_on",   {31'b0, imem_req_o}, 32'd1);
        chk("s6_req_addr", imem_addr_o, 32'h408);
        drain(200);

        // random mixed stream from a halfword target, random grant/latency/ready
        gnt_rand = 1'b1; rnd_ready = 1'b1; lat_min = 1; lat_max = 3;
        hws.push_back(16'hFFFF);        // low half of 0x800, never presented
        pc = 32'h802;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                c      = 16'($urandom);
                c[1:0] = 2'($urandom_range(0, 2));
                expect_inst({16'h0000, c}, pc, 1'b1);
                hws.push_back(c);
                pc += 32'd2;
            end else begin
                w      = $urandom;
                w[1:0] = 2'b11;
                expect_inst(w, pc, 1'b0);
                hws.push_back(w[15:0]);
                hws.push_back(w[31:16]);
                pc += 32'd4;
            end
        end
        if (hws.size() % 2 != 0) hws.push_back(16'h0001);
        for (int k = 0; k < hws.size() / 2; k++)
            mem[32'h800 + 32'(4 * k)] = {hws[2 * k + 1], hws[2 * k]};
        do_flush(32'h802);
        drain(3000);

        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
